// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debouncer
//  Purpose  : Multi-channel conditioner for raw active-low push buttons.
//             Each input is synchronised to CLK through two flops, then
//             filtered on a slow sample tick. A channel accepts a new level
//             only after STABLE_CNT consecutive ticks have all seen that new
//             value. The block reports the clean level together with
//             single-cycle press (1->0) and release (0->1) strobes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK           in   1     system clock, rising edge
//    RST           in   1     synchronous active-high reset
//    iSWITCH       in   N_CH  raw asynchronous switch inputs (0 = pressed)
//    oSWITCH       out  N_CH  debounced level, same polarity, registered
//    press_pulse   out  N_CH  one-cycle strobe when oSWITCH[i] goes 1->0
//    release_pulse out  N_CH  one-cycle strobe when oSWITCH[i] goes 0->1
//    sample_tick   out  1     one-cycle strobe marking each sample instant
// ----------------------------------------------------------------------------
//  Parameters
//    N_CH       number of switch channels
//    TICK_DIV   CLK cycles per sample tick (>= 2)
//    STABLE_CNT consecutive disagreeing ticks needed to accept a level (>= 1)
// ============================================================================
module switch_debouncer #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 12000,
    parameter int STABLE_CNT = 20
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] iSWITCH,
    output logic [N_CH-1:0] oSWITCH,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            sample_tick
);

    localparam int PC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Resetting to ones means a released switch never
    // looks like a transition coming out of reset.
    // ------------------------------------------------------------------------
    logic [N_CH-1:0] s1_q;
    logic [N_CH-1:0] s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= iSWITCH;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler. tick_w is the internal sample condition; sample_tick is its
    // registered copy, so the visible strobe trails the internal one by a
    // cycle and lines up with the cycle in which any level update appears.
    // ------------------------------------------------------------------------
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            tick_w;
    logic            sample_tick_q;

    assign tick_w = (pc_q == PC_LAST);

    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (tick_w) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q          <= '0;
            sample_tick_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            sample_tick_q <= tick_w;
        end
    end

    assign sample_tick = sample_tick_q;

    // ------------------------------------------------------------------------
    // Per-channel filter. The counter tracks how many consecutive ticks have
    // disagreed with the current output; a single agreeing tick clears it.
    // It is cleared on acceptance too, so it never passes CNT_LAST.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             lvl_q;
            logic             lvl_d;
            logic             press_q;
            logic             press_d;
            logic             rel_q;
            logic             rel_d;

            always_comb begin
                cnt_d   = cnt_q;
                lvl_d   = lvl_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
                if (tick_w) begin
                    if (s2_q[gi] == lvl_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Accepting a new level: the direction of the change
                        // is fully given by the new value, since it differs
                        // from the old one.
                        lvl_d   = s2_q[gi];
                        cnt_d   = '0;
                        press_d = ~s2_q[gi];
                        rel_d   = s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_q   <= '0;
                    lvl_q   <= 1'b1;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    lvl_q   <= lvl_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                end
            end

            assign oSWITCH[gi]       = lvl_q;
            assign press_pulse[gi]   = press_q;
            assign release_pulse[gi] = rel_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debouncer
//  Purpose  : Self-checking bench for switch_debouncer (TICK_DIV=4,
//             STABLE_CNT=3). A cycle-level reference model built from the
//             acceptance rule (a level changes when the last STABLE_CNT tick
//             samples all differ from it) predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N_CH-1:0] iSWITCH = '1;
    logic [N_CH-1:0] oSWITCH;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic            sample_tick;

    switch_debouncer #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .iSWITCH       (iSWITCH),
        .oSWITCH       (oSWITCH),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .sample_tick   (sample_tick)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [N_CH-1:0] m_s1, m_s2, m_out, m_press, m_rel;
    logic            m_tick;
    int              m_n;
    logic [N_CH-1:0] m_hist[$];

    // Directed tallies of DUT strobes
    int press_seen [N_CH];
    int rel_seen   [N_CH];

    task automatic check(input string tag, input logic [N_CH-1:0] obs,
                         input logic [N_CH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [N_CH-1:0] smp;
        bit              all_diff;
        if (RST) begin
            m_s1 = '1; m_s2 = '1; m_out = '1;
            m_press = '0; m_rel = '0; m_tick = 1'b0;
            m_n = 0;
            m_hist.delete();
        end else begin
            smp     = m_s2;
            m_s2    = m_s1;
            m_s1    = iSWITCH;
            m_n++;
            m_tick  = ((m_n % TICK_DIV) == 0);
            m_press = '0;
            m_rel   = '0;
            if (m_tick) begin
                m_hist.push_back(smp);
                if (m_hist.size() > STABLE_CNT) void'(m_hist.pop_front());
                if (m_hist.size() == STABLE_CNT) begin
                    for (int c = 0; c < N_CH; c++) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < STABLE_CNT; k++)
                            if (m_hist[k][c] == m_out[c]) all_diff = 1'b0;
                        if (all_diff) begin
                            if (m_out[c]) m_press[c] = 1'b1;
                            else          m_rel[c]   = 1'b1;
                            m_out[c] = ~m_out[c];
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N_CH-1:0] sw);
        RST     = rst;
        iSWITCH = sw;
        @(posedge CLK);
        model_edge();
        #1;
        check("oSWITCH", oSWITCH, m_out);
        check("press_pulse", press_pulse, m_press);
        check("release_pulse", release_pulse, m_rel);
        check("sample_tick", {{(N_CH-1){1'b0}}, sample_tick}, {{(N_CH-1){1'b0}}, m_tick});
        for (int c = 0; c < N_CH; c++) begin
            if (press_pulse[c])   press_seen[c]++;
            if (release_pulse[c]) rel_seen[c]++;
        end
    endtask

    task automatic clear_tally();
        for (int c = 0; c < N_CH; c++) begin
            press_seen[c] = 0;
            rel_seen[c]   = 0;
        end
    endtask

    initial begin
        logic [N_CH-1:0] sw;
        int              k;
        int              guard;

        clear_tally();

        // Reset held for 3 cycles with all switches pressed
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0000);
            check("reset_level", oSWITCH, 4'b1111);
            check("reset_strobes", press_pulse | release_pulse, 4'b0000);
        end

        // Inputs already pressed: all four accept together
        clear_tally();
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0000);
        check("all_pressed_level", oSWITCH, 4'b0000);
        for (int c = 0; c < N_CH; c++) check_int("all_press_once", press_seen[c], 1);

        // Release all
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111);
        check("all_released_level", oSWITCH, 4'b1111);

        // Clean press on channel 3
        clear_tally();
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0111);
        check("ch3_press_level", oSWITCH, 4'b0111);
        check_int("ch3_press_once", press_seen[3], 1);
        check_int("ch3_no_release", rel_seen[3], 0);

        // Bounce on channel 1 with an 8-cycle period: ticks alternate
        clear_tally();
        for (int i = 0; i < 100; i++) begin
            sw = 4'b0111;
            sw[1] = ((i / 4) % 2 == 0) ? 1'b0 : 1'b1;
            step(1'b0, sw);
            check("bounce_ch1_level", {3'b000, oSWITCH[1]}, 4'b0001);
        end
        check_int("bounce_no_press", press_seen[1], 0);
        check_int("bounce_no_release", rel_seen[1], 0);

        // Press then release channel 0
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1110);
        check("ch0_press_level", oSWITCH, 4'b1110);
        clear_tally();
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111);
        check("ch0_release_level", oSWITCH, 4'b1111);
        check_int("ch0_release_once", rel_seen[0], 1);
        check_int("ch0_no_press", press_seen[0], 0);

        // Simultaneous press on channels 1 and 2
        clear_tally();
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1001);
        check("sim_press_level", oSWITCH, 4'b1001);
        check_int("sim_press_ch1", press_seen[1], 1);
        check_int("sim_press_ch2", press_seen[2], 1);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111);

        // Reset after two disagreeing ticks on channel 2
        k = 0;
        guard = 0;
        while (k < 2 && guard < 50) begin
            step(1'b0, 4'b1011);
            if (m_tick && m_hist.size() > 0 && m_hist[m_hist.size()-1][2] == 1'b0) k++;
            guard++;
        end
        check_int("midcount_two_ticks", k, 2);
        step(1'b1, 4'b1011);
        clear_tally();
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1011);
        check("midcount_no_early_change", oSWITCH, 4'b1111);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1011);
        check("midcount_accept", oSWITCH, 4'b1011);
        check_int("midcount_press_once", press_seen[2], 1);

        // Randomised phase: sparse toggles and occasional resets
        sw = 4'b1111;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) sw[$urandom_range(0, N_CH-1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) sw[$urandom_range(0, N_CH-1)] ^= 1'b1;
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, sw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
